// File: rtl/reorder_commit_unit.sv
// Program-ordered micro-op trace with per-queue completion credits; retires up to
// RETIRE_WIDTH entries per cycle and pushes finished instruction IDs into a commit FIFO.
module rcu_credit #(
  parameter int CNT_WIDTH = 7,
  parameter int DEC_WIDTH = 2
) (
  input  logic                 clk_i,
  input  logic                 ars_i,
  input  logic                 clr,
  input  logic                 inc,
  input  logic [DEC_WIDTH-1:0] dec,
  output logic [CNT_WIDTH-1:0] credit
);
  always_ff @(posedge clk_i or posedge ars_i)
    if (ars_i)    credit <= '0;
    else if (clr) credit <= '0;
    else          credit <= credit + CNT_WIDTH'(inc) - CNT_WIDTH'(dec);
endmodule

module reorder_commit_unit #(
  parameter int   NUM_QUEUES   = 8,
  parameter int   DEPTH        = 64,
  parameter int   RETIRE_WIDTH = 2,
  parameter int   COMMIT_DEPTH = 16,
  parameter logic BREAKPOINT   = 1'b1,
  localparam int  ID_WIDTH     = $clog2(DEPTH),
  localparam int  SEL_WIDTH    = $clog2(NUM_QUEUES),
  localparam int  CNT_WIDTH    = $clog2(DEPTH+1)
) (
  input  logic                  clk_i,
  input  logic                  ars_i,
  input  logic                  trace_push_i,
  input  logic [SEL_WIDTH-1:0]  trace_sel_i,
  input  logic                  trace_break_i,
  input  logic [ID_WIDTH-1:0]   trace_id_value_i,
  input  logic                  trace_update_i,
  input  logic                  flush_i,
  input  logic [NUM_QUEUES-1:0] queues_status_push_i,
  input  logic                  commit_pull_i,
  output logic                  full_o,
  output logic [CNT_WIDTH-1:0]  count_o,
  output logic                  commit_valid_o,
  output logic [ID_WIDTH-1:0]   commit_id_o,
  output logic                  commit_full_o
);
  localparam int DEC_WIDTH = $clog2(RETIRE_WIDTH+1);
  localparam int CP_W      = $clog2(COMMIT_DEPTH);
  localparam int CC_W      = $clog2(COMMIT_DEPTH+1);

  logic [ID_WIDTH-1:0]  head, tail, newest;
  logic [CNT_WIDTH-1:0] count;
  logic [SEL_WIDTH-1:0] sel_mem [DEPTH];
  logic [DEPTH-1:0]     brk_mem;
  logic [ID_WIDTH-1:0]  id_mem  [DEPTH];

  logic [NUM_QUEUES-1:0][CNT_WIDTH-1:0] credit;
  logic [NUM_QUEUES-1:0][DEC_WIDTH-1:0] dec;
  logic [DEC_WIDTH-1:0] n_ret;
  logic                 cm_we, cm_pop, push_ok, upd_ok;
  logic [ID_WIDTH-1:0]  cm_wid;

  logic [ID_WIDTH-1:0]  cmem [COMMIT_DEPTH];
  logic [CP_W-1:0]      c_rd, c_wr;
  logic [CC_W-1:0]      c_cnt;

  assign full_o         = (count == CNT_WIDTH'(DEPTH));
  assign count_o        = count;
  assign newest         = tail - 1'b1;
  assign commit_valid_o = (c_cnt != '0);
  assign commit_full_o  = (c_cnt == CC_W'(COMMIT_DEPTH));
  assign commit_id_o    = commit_valid_o ? cmem[c_rd] : '0;
  assign cm_pop         = commit_pull_i && commit_valid_o;

  // In-order scan from head; dec[s] doubles as the count of earlier same-queue slots.
  always_comb begin
    logic                 go, brk_seen;
    logic [ID_WIDTH-1:0]  idx;
    logic [SEL_WIDTH-1:0] s;
    dec      = '0;
    n_ret    = '0;
    cm_we    = 1'b0;
    cm_wid   = '0;
    go       = !flush_i;
    brk_seen = 1'b0;
    idx      = '0;
    s        = '0;
    for (int j = 0; j < RETIRE_WIDTH; j++) begin
      idx = head + ID_WIDTH'(j);
      s   = sel_mem[idx];
      if (go && (CNT_WIDTH'(j) < count) && (credit[s] > CNT_WIDTH'(dec[s])) &&
          (!brk_mem[idx] || (!brk_seen && !commit_full_o))) begin
        dec[s] = dec[s] + 1'b1;
        n_ret  = n_ret + 1'b1;
        if (brk_mem[idx]) begin
          brk_seen = 1'b1;
          cm_we    = 1'b1;
          cm_wid   = id_mem[idx];
        end
      end else begin
        go = 1'b0;
      end
    end
  end

  assign push_ok = trace_push_i && !full_o && !flush_i;
  // The newest entry is retiring only when the whole trace drains this cycle.
  assign upd_ok  = trace_update_i && !flush_i && (count != '0) &&
                   (CNT_WIDTH'(n_ret) != count);

  always_ff @(posedge clk_i or posedge ars_i)
    if (ars_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + ID_WIDTH'(n_ret);
      tail  <= tail + ID_WIDTH'(push_ok);
      count <= count + CNT_WIDTH'(push_ok) - CNT_WIDTH'(n_ret);
    end

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      sel_mem[tail] <= trace_sel_i;
      brk_mem[tail] <= (trace_break_i == BREAKPOINT);
      id_mem[tail]  <= trace_id_value_i;
    end
    if (upd_ok) begin
      brk_mem[newest] <= 1'b1;
      id_mem[newest]  <= trace_id_value_i;
    end
  end

  for (genvar q = 0; q < NUM_QUEUES; q++) begin : g_credit
    rcu_credit #(.CNT_WIDTH(CNT_WIDTH), .DEC_WIDTH(DEC_WIDTH)) u_credit (
      .clk_i  (clk_i),
      .ars_i  (ars_i),
      .clr    (flush_i),
      .inc    (queues_status_push_i[q]),
      .dec    (dec[q]),
      .credit (credit[q])
    );
  end

  always_ff @(posedge clk_i or posedge ars_i)
    if (ars_i) begin
      c_rd  <= '0;
      c_wr  <= '0;
      c_cnt <= '0;
    end else begin
      c_rd  <= c_rd + CP_W'(cm_pop);
      c_wr  <= c_wr + CP_W'(cm_we);
      c_cnt <= c_cnt + CC_W'(cm_we) - CC_W'(cm_pop);
    end

  always_ff @(posedge clk_i)
    if (cm_we) cmem[c_wr] <= cm_wid;

endmodule

// File: tb/tb_reorder_commit_unit.sv
// Directed bench: expected commit IDs are queued at stimulus time and checked by a
// monitor on every commit pop; occupancy/flag checks are done inline.
module tb_reorder_commit_unit;
  localparam int NQ = 8, DEPTH = 64, RW = 2, CD = 16;

  logic       clk_i = 0, ars_i = 1;
  logic       trace_push_i = 0, trace_break_i = 0, trace_update_i = 0, flush_i = 0;
  logic [2:0] trace_sel_i = 0;
  logic [5:0] trace_id_value_i = 0;
  logic [7:0] queues_status_push_i = 0;
  logic       commit_pull_i = 0;
  logic       full_o, commit_valid_o, commit_full_o;
  logic [6:0] count_o;
  logic [5:0] commit_id_o;

  int n_vec = 0, n_err = 0;
  int exp_q[$];

  reorder_commit_unit #(.NUM_QUEUES(NQ), .DEPTH(DEPTH), .RETIRE_WIDTH(RW),
                        .COMMIT_DEPTH(CD), .BREAKPOINT(1'b1)) dut (
    .clk_i(clk_i), .ars_i(ars_i), .trace_push_i(trace_push_i), .trace_sel_i(trace_sel_i),
    .trace_break_i(trace_break_i), .trace_id_value_i(trace_id_value_i),
    .trace_update_i(trace_update_i), .flush_i(flush_i),
    .queues_status_push_i(queues_status_push_i), .commit_pull_i(commit_pull_i),
    .full_o(full_o), .count_o(count_o), .commit_valid_o(commit_valid_o),
    .commit_id_o(commit_id_o), .commit_full_o(commit_full_o));

  always #5 clk_i = ~clk_i;

  // Scoreboard monitor: a pop happens at the next rising edge.
  always @(negedge clk_i) begin
    if (!ars_i && commit_valid_o && commit_pull_i) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL commit_pop: got id %0d, required none pending", commit_id_o);
      end else begin
        int e;
        e = exp_q.pop_front();
        if (commit_id_o !== 6'(e)) begin
          n_err++;
          $display("FAIL commit_pop: got id %0d, required %0d", commit_id_o, e);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk_i); #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic push_op(input int s, input bit b, input int id);
    trace_push_i = 1; trace_sel_i = 3'(s); trace_break_i = b; trace_id_value_i = 6'(id);
    step();
    trace_push_i = 0; trace_break_i = 0;
  endtask

  task automatic status(input logic [7:0] m);
    queues_status_push_i = m;
    step();
    queues_status_push_i = 0;
  endtask

  task automatic drain();
    int i;
    commit_pull_i = 1;
    for (i = 0; i < 40 && commit_valid_o; i++) step();
    commit_pull_i = 0;
    check("drain_done", int'(commit_valid_o), 0);
  endtask

  initial begin
    #12 ars_i = 0;
    step();
    // reset state
    check("rst_full", int'(full_o), 0);
    check("rst_count", int'(count_o), 0);
    check("rst_cvalid", int'(commit_valid_o), 0);
    check("rst_cid", int'(commit_id_o), 0);
    check("rst_cfull", int'(commit_full_o), 0);

    // single instruction, id 7 on queues 2,5,2
    push_op(2, 0, 0); push_op(5, 0, 0); push_op(2, 1, 7);
    exp_q.push_back(7);
    check("instr_count", int'(count_o), 3);
    status(8'h20); status(8'h04); status(8'h04);
    check("instr_not_yet", int'(commit_valid_o), 0);
    step();
    check("instr_cvalid", int'(commit_valid_o), 1);
    check("instr_cid", int'(commit_id_o), 7);
    check("instr_count0", int'(count_o), 0);
    drain();

    // out-of-order completion keeps commit order
    push_op(0, 1, 1); push_op(1, 1, 2);
    exp_q.push_back(1); exp_q.push_back(2);
    status(8'h02);
    repeat (10) step();
    check("ooo_held", int'(commit_valid_o), 0);
    check("ooo_count", int'(count_o), 2);
    status(8'h01);
    step(); step();
    check("ooo_count0", int'(count_o), 0);
    drain();

    // retire width 2
    push_op(0, 0, 0); push_op(1, 0, 0); push_op(2, 0, 0); push_op(3, 0, 0);
    status(8'h0F);
    check("rw_count4", int'(count_o), 4);
    step();
    check("rw_count2", int'(count_o), 2);
    step();
    check("rw_count0", int'(count_o), 0);
    push_op(4, 1, 10); push_op(5, 1, 11);
    exp_q.push_back(10); exp_q.push_back(11);
    status(8'h30);
    step();
    check("brk_one_per_cyc", int'(count_o), 1);
    check("brk_first_id", int'(commit_id_o), 10);
    step();
    check("brk_count0", int'(count_o), 0);
    drain();

    // trace full
    for (int i = 0; i < DEPTH; i++) push_op(6, 0, 0);
    check("full_flag", int'(full_o), 1);
    check("full_count", int'(count_o), 64);
    push_op(6, 1, 33);
    check("full_drop", int'(count_o), 64);
    flush_i = 1; step(); flush_i = 0;
    check("full_flush_count", int'(count_o), 0);
    check("full_flush_flag", int'(full_o), 0);

    // commit FIFO backpressure
    for (int i = 0; i < 17; i++) begin
      push_op(7, 1, 20 + i);
      exp_q.push_back(20 + i);
    end
    for (int i = 0; i < 17; i++) status(8'h80);
    step();
    check("cf_full", int'(commit_full_o), 1);
    check("cf_held", int'(count_o), 1);
    commit_pull_i = 1; step(); commit_pull_i = 0;
    check("cf_after_pull", int'(commit_full_o), 0);
    check("cf_still_held", int'(count_o), 1);
    step();
    check("cf_retired", int'(count_o), 0);
    check("cf_full_again", int'(commit_full_o), 1);
    drain();

    // trace update
    push_op(3, 0, 0); push_op(4, 0, 0); push_op(5, 0, 0);
    trace_update_i = 1; trace_id_value_i = 9; step(); trace_update_i = 0;
    exp_q.push_back(9);
    status(8'h38);
    step(); step();
    check("upd_count0", int'(count_o), 0);
    check("upd_cid", int'(commit_id_o), 9);
    drain();

    // flush preserves commit FIFO and clears credits
    push_op(0, 1, 12);
    exp_q.push_back(12);
    status(8'h01);
    step();
    check("fl_pre_cid", int'(commit_id_o), 12);
    push_op(1, 0, 0); push_op(2, 0, 0); push_op(3, 0, 0); push_op(4, 0, 0);
    status(8'h10);
    flush_i = 1; step(); flush_i = 0;
    check("fl_count", int'(count_o), 0);
    check("fl_cvalid", int'(commit_valid_o), 1);
    check("fl_cid", int'(commit_id_o), 12);
    push_op(4, 1, 13);
    exp_q.push_back(13);
    step(); step(); step();
    check("fl_credit_cleared", int'(count_o), 1);
    status(8'h10);
    step();
    check("fl_retire", int'(count_o), 0);
    drain();

    // reset mid-traffic
    push_op(0, 1, 40); push_op(0, 1, 41);
    status(8'h01); status(8'h01);
    for (int i = 0; i < 5; i++) push_op(5, 0, 0);
    check("mr_commits", int'(commit_valid_o), 1);
    #2 ars_i = 1;
    #1;
    check("mr_count", int'(count_o), 0);
    check("mr_cvalid", int'(commit_valid_o), 0);
    check("mr_cid", int'(commit_id_o), 0);
    check("mr_full", int'(full_o) | int'(commit_full_o), 0);
    step();
    ars_i = 0;
    push_op(6, 1, 50);
    exp_q.push_back(50);
    check("mr_count1", int'(count_o), 1);
    status(8'h40);
    step();
    check("mr_cid50", int'(commit_id_o), 50);
    check("mr_count0", int'(count_o), 0);
    drain();

    check("scoreboard_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, required finish");
    $fatal(1);
  end
endmodule
